// File: rtl/keypad_if.sv
// Pin-side and core-side signals of the 4x4 matrix keypad scanner.
// The scanner uses the slave modport; the board or bench drives rows through the master modport.
interface keypad_if;
  logic [3:0]  rows;
  logic [3:0]  cols;
  logic [3:0]  key;
  logic        key_valid;
  logic        key_held;
  logic [15:0] history;

  modport slave  (input rows, output cols, key, key_valid, key_held, history);
  modport master (output rows, input cols, key, key_valid, key_held, history);
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column scan, sweep-level debounce, hex key output.
// Optional KEYPAD_HISTORY_EN keeps a 4-deep key history register.
module keypad_scanner #(
  parameter int ClkFreq       = 100_000_000,
  parameter int ScanHz        = 1000,
  parameter int DebounceScans = 4
) (
  input  logic     clk,
  input  logic     rst,
  keypad_if.slave  kp
);
  localparam int TickCycles = ClkFreq / ScanHz;
  localparam int TickW      = (TickCycles > 1) ? $clog2(TickCycles) : 1;
  localparam int CntW       = $clog2(DebounceScans + 1);
  localparam logic [TickW-1:0] TickMax = TickW'(TickCycles - 1);
  localparam logic [CntW-1:0]  CntMax  = CntW'(DebounceScans);
  localparam logic [CntW-1:0]  CntOne  = CntW'(1);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED} state_t;

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'd0:  code = 4'h1;  4'd1:  code = 4'h2;  4'd2:  code = 4'h3;  4'd3:  code = 4'hA;
      4'd4:  code = 4'h4;  4'd5:  code = 4'h5;  4'd6:  code = 4'h6;  4'd7:  code = 4'hB;
      4'd8:  code = 4'h7;  4'd9:  code = 4'h8;  4'd10: code = 4'h9;  4'd11: code = 4'hC;
      4'd12: code = 4'h0;  4'd13: code = 4'hF;  4'd14: code = 4'hE;  default: code = 4'hD;
    endcase
    return code;
  endfunction

  logic [3:0]       rows_s1_q, rows_s2_q;
  logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
  logic [1:0]       col_q, col_d;
  logic [1:0]       hits_q, hits_d;
  logic [3:0]       code_q, code_d;
  state_t           state_q, state_d;
  logic [3:0]       cand_q, cand_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [3:0]       key_q, key_d;
  logic             key_valid_q, key_valid_d;
  logic             key_held_q, key_held_d;

  logic             tick, sweep_end;
  logic [3:0]       rows_low;
  logic [2:0]       col_hits, hits_sum;
  logic [1:0]       row_idx, hits_sat;
  logic [3:0]       code_this;
  logic [CntW-1:0]  cnt_inc;

  // Scan datapath: tick counter, column stepper and per-sweep key accumulator.
  always_comb begin
    tick       = (tick_cnt_q == TickMax);
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    sweep_end  = tick && (col_q == 2'd3);
    rows_low   = ~rows_s2_q;
    col_hits   = 3'(rows_low[0]) + 3'(rows_low[1]) + 3'(rows_low[2]) + 3'(rows_low[3]);
    row_idx    = rows_low[0] ? 2'd0 : rows_low[1] ? 2'd1 : rows_low[2] ? 2'd2 : 2'd3;
    hits_sum   = {1'b0, hits_q} + col_hits;
    hits_sat   = (hits_sum >= 3'd2) ? 2'd2 : hits_sum[1:0];
    code_this  = (hits_q == 2'd0 && col_hits == 3'd1) ? key_code(row_idx, col_q) : code_q;
    col_d      = col_q;
    hits_d     = hits_q;
    code_d     = code_q;
    if (tick) begin
      col_d  = col_q + 2'd1;
      hits_d = sweep_end ? 2'd0 : hits_sat;
      code_d = sweep_end ? 4'h0 : code_this;
    end
  end

  // Debounce FSM; only a completed sweep can move it.
  always_comb begin
    cnt_inc     = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
    state_d     = state_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    key_d       = key_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    if (sweep_end) begin
      case (state_q)
        IDLE: begin
          if (hits_sat == 2'd1) begin
            state_d = DEBOUNCE;
            cand_d  = code_this;
            cnt_d   = CntOne;
          end
        end
        DEBOUNCE: begin
          if (hits_sat == 2'd1) begin
            if (code_this == cand_q) begin
              if (cnt_inc == CntMax) begin
                state_d     = PRESSED;
                key_d       = cand_q;
                key_valid_d = 1'b1;
                key_held_d  = 1'b1;
                cnt_d       = '0;
              end else begin
                cnt_d = cnt_inc;
              end
            end else begin
              cand_d = code_this;
              cnt_d  = CntOne;
            end
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        PRESSED: begin
          if (hits_sat == 2'd0) begin
            if (cnt_inc == CntMax) begin
              state_d    = IDLE;
              key_held_d = 1'b0;
              cnt_d      = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            cnt_d = '0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

`ifdef KEYPAD_HISTORY_EN
  logic [15:0] history_q, history_d;
  always_comb begin
    history_d = key_valid_d ? {history_q[11:0], key_d} : history_q;
  end
  assign kp.history = history_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rows_s1_q   <= 4'hF;
      rows_s2_q   <= 4'hF;
      tick_cnt_q  <= '0;
      col_q       <= 2'd0;
      hits_q      <= 2'd0;
      code_q      <= 4'h0;
      state_q     <= IDLE;
      cand_q      <= 4'h0;
      cnt_q       <= '0;
      key_q       <= 4'h0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
`ifdef KEYPAD_HISTORY_EN
      history_q   <= 16'h0000;
`endif
    end else begin
      rows_s1_q   <= kp.rows;
      rows_s2_q   <= rows_s1_q;
      tick_cnt_q  <= tick_cnt_d;
      col_q       <= col_d;
      hits_q      <= hits_d;
      code_q      <= code_d;
      state_q     <= state_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
`ifdef KEYPAD_HISTORY_EN
      history_q   <= history_d;
`endif
    end
  end

  assign kp.cols      = ~(4'b0001 << col_q);
  assign kp.key       = key_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_held  = key_held_q;
`ifndef KEYPAD_HISTORY_EN
  assign kp.history   = {12'h000, key_q};
`endif
endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a resistive keypad model answers the column scan,
// and press/bounce/rollover/reset scenarios are checked against hand-computed values.
module tb_keypad_scanner;
  localparam int SweepCycles = 40;
  localparam int K1 = 0, K2 = 1, K3 = 2, KA = 3, K5 = 5, K9 = 10, KC = 11, KE = 14, KD = 15;

  logic        clk;
  logic        rst;
  logic [15:0] pressed;
  int          assert_cnt;
  int          fail_cnt;
  int          pulse_cnt;
  int          pulse_base;
  logic        kv_prev;

  keypad_if kp();

  keypad_scanner #(.ClkFreq(1000), .ScanHz(100), .DebounceScans(4)) dut (
    .clk (clk),
    .rst (rst),
    .kp  (kp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A row reads low when any pressed key in it sits on the column currently driven low.
  for (genvar gi = 0; gi < 4; gi++) begin : g_rows
    assign kp.rows[gi] = ~|(pressed[gi*4 +: 4] & ~kp.cols);
  end

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    assert_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic run_sweeps(input int n);
    repeat (n * SweepCycles) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    check_eq("cols_onehot", 16'($countones(~kp.cols)), 16'd1);
    if (kp.key_valid) begin
      pulse_cnt++;
      check_eq("kv_held_same_cycle", 16'(kp.key_held), 16'd1);
      check_eq("kv_not_consecutive", 16'(kv_prev), 16'd0);
    end
    kv_prev = kp.key_valid;
  end

  initial begin
    assert_cnt = 0;
    fail_cnt   = 0;
    pulse_cnt  = 0;
    kv_prev    = 1'b0;
    pressed    = 16'h0000;
    rst        = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_cols", 16'(kp.cols), 16'h000E);
    check_eq("rst_key", 16'(kp.key), 16'h0000);
    check_eq("rst_key_valid", 16'(kp.key_valid), 16'h0000);
    check_eq("rst_key_held", 16'(kp.key_held), 16'h0000);
    check_eq("rst_history", kp.history, 16'h0000);
    rst = 1'b0;

    // 1: steady '5'
    $display("step 1: hold key 5");
    pulse_base = pulse_cnt;
    pressed[K5] = 1'b1;
    repeat (5 * SweepCycles + 3) @(posedge clk);
    #1;
    check_eq("t1_pulses", 16'(pulse_cnt - pulse_base), 16'd1);
    check_eq("t1_key", 16'(kp.key), 16'h0005);
    check_eq("t1_held", 16'(kp.key_held), 16'd1);
    run_sweeps(10);
    check_eq("t1_no_repeat", 16'(pulse_cnt - pulse_base), 16'd1);
    pressed = 16'h0000;
    run_sweeps(6);
    check_eq("t1_released", 16'(kp.key_held), 16'd0);
    check_eq("t1_key_kept", 16'(kp.key), 16'h0005);

    // 2: bouncing '9'
    $display("step 2: bounce key 9");
    pulse_base = pulse_cnt;
    pressed[K9] = 1'b1; run_sweeps(1);
    pressed[K9] = 1'b0; run_sweeps(1);
    pressed[K9] = 1'b1; run_sweeps(1);
    check_eq("t2_no_pulse_bounce", 16'(pulse_cnt - pulse_base), 16'd0);
    run_sweeps(2);
    check_eq("t2_no_pulse_early", 16'(pulse_cnt - pulse_base), 16'd0);
    run_sweeps(4);
    check_eq("t2_pulses", 16'(pulse_cnt - pulse_base), 16'd1);
    check_eq("t2_key", 16'(kp.key), 16'h0009);
    pressed = 16'h0000;
    run_sweeps(6);

    // 3: two keys, then one released
    $display("step 3: keys 1+2, then release 2");
    pulse_base = pulse_cnt;
    pressed[K1] = 1'b1;
    pressed[K2] = 1'b1;
    run_sweeps(8);
    check_eq("t3_multi_ignored", 16'(pulse_cnt - pulse_base), 16'd0);
    check_eq("t3_not_held", 16'(kp.key_held), 16'd0);
    pressed[K2] = 1'b0;
    run_sweeps(6);
    check_eq("t3_pulses", 16'(pulse_cnt - pulse_base), 16'd1);
    check_eq("t3_key", 16'(kp.key), 16'h0001);
    pressed = 16'h0000;
    run_sweeps(6);

    // 4: 'E' held, 'D' added mid-press, release timing, re-press
    $display("step 4: key E, rollover D, release, E again");
    pulse_base = pulse_cnt;
    pressed[KE] = 1'b1;
    run_sweeps(6);
    check_eq("t4_first_pulse", 16'(pulse_cnt - pulse_base), 16'd1);
    check_eq("t4_key", 16'(kp.key), 16'h000E);
    pressed[KD] = 1'b1;
    run_sweeps(8);
    check_eq("t4_rollover_ignored", 16'(pulse_cnt - pulse_base), 16'd1);
    check_eq("t4_rollover_key", 16'(kp.key), 16'h000E);
    check_eq("t4_rollover_held", 16'(kp.key_held), 16'd1);
    pressed = 16'h0000;
    run_sweeps(3);
    check_eq("t4_held_3_empty", 16'(kp.key_held), 16'd1);
    run_sweeps(2);
    #3;
    check_eq("t4_held_fell", 16'(kp.key_held), 16'd0);
    pressed[KE] = 1'b1;
    run_sweeps(6);
    check_eq("t4_second_pulse", 16'(pulse_cnt - pulse_base), 16'd2);
    check_eq("t4_key_again", 16'(kp.key), 16'h000E);
    pressed = 16'h0000;
    run_sweeps(6);

    // 5: reset while 'C' held
    $display("step 5: reset while key C held");
    pulse_base = pulse_cnt;
    pressed[KC] = 1'b1;
    run_sweeps(6);
    check_eq("t5_pre_pulse", 16'(pulse_cnt - pulse_base), 16'd1);
    check_eq("t5_pre_key", 16'(kp.key), 16'h000C);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("t5_rst_cols", 16'(kp.cols), 16'h000E);
    check_eq("t5_rst_key", 16'(kp.key), 16'h0000);
    check_eq("t5_rst_held", 16'(kp.key_held), 16'd0);
    check_eq("t5_rst_valid", 16'(kp.key_valid), 16'd0);
    check_eq("t5_rst_history", kp.history, 16'h0000);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    pulse_base = pulse_cnt;
    run_sweeps(6);
    check_eq("t5_post_pulse", 16'(pulse_cnt - pulse_base), 16'd1);
    check_eq("t5_post_key", 16'(kp.key), 16'h000C);
    run_sweeps(6);
    check_eq("t5_no_repeat", 16'(pulse_cnt - pulse_base), 16'd1);
    pressed = 16'h0000;
    run_sweeps(6);

    // 6: history of 1,2,3,A
    $display("step 6: press and release 1 2 3 A");
    pulse_base = pulse_cnt;
    pressed[K1] = 1'b1; run_sweeps(6); pressed = 16'h0000; run_sweeps(6);
    pressed[K2] = 1'b1; run_sweeps(6); pressed = 16'h0000; run_sweeps(6);
    pressed[K3] = 1'b1; run_sweeps(6); pressed = 16'h0000; run_sweeps(6);
    pressed[KA] = 1'b1; run_sweeps(6); pressed = 16'h0000; run_sweeps(6);
    check_eq("t6_pulses", 16'(pulse_cnt - pulse_base), 16'd4);
    check_eq("t6_key", 16'(kp.key), 16'h000A);
`ifdef KEYPAD_HISTORY_EN
    check_eq("t6_history", kp.history, 16'h123A);
`else
    check_eq("t6_history", kp.history, 16'h000A);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end
endmodule
